// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
// Optional build macro MD_DIV0_GUARD_EN: divide-by-zero finishes in one cycle and leaves HI/LO untouched.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDop,
    input  logic        HIwrite,
    input  logic        LOwrite,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_next;
    logic [31:0] count;
    logic [31:0] op_a, op_b;
    logic [1:0]  op_sel;
    logic        skip_wb;
    logic        op_valid;
    logic        accept;

    assign op_valid = (MDop[2] == 1'b0);
    assign accept   = (state == IDLE) && start && op_valid;
    assign busy     = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = RUN;
            RUN:  if (count == 32'd1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Results are formed from the latched operands and consumed at the completion edge.
    logic        is_signed;
    logic [63:0] a_ext, b_ext, product;
    logic [31:0] dvd_mag, dvs_mag, q_mag, r_mag, quot, rem;
    logic [31:0] res_hi, res_lo;

    always_comb begin
        is_signed = op_sel[0];
        a_ext     = is_signed ? {{32{op_a[31]}}, op_a} : {32'd0, op_a};
        b_ext     = is_signed ? {{32{op_b[31]}}, op_b} : {32'd0, op_b};
        product   = a_ext * b_ext;

        dvd_mag = (is_signed && op_a[31]) ? (32'd0 - op_a) : op_a;
        dvs_mag = (is_signed && op_b[31]) ? (32'd0 - op_b) : op_b;
        q_mag   = (dvs_mag == 32'd0) ? 32'hFFFF_FFFF : dvd_mag / dvs_mag;
        r_mag   = (dvs_mag == 32'd0) ? dvd_mag : dvd_mag % dvs_mag;
        quot    = (is_signed && (op_a[31] ^ op_b[31])) ? (32'd0 - q_mag) : q_mag;
        rem     = (is_signed && op_a[31]) ? (32'd0 - r_mag) : r_mag;

        if (op_sel[1] == 1'b0) begin
            res_hi = product[63:32];
            res_lo = product[31:0];
        end else if (op_b == 32'd0) begin
            res_hi = op_a;
            res_lo = 32'hFFFF_FFFF;
        end else begin
            res_hi = rem;
            res_lo = quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            HI      <= 32'd0;
            LO      <= 32'd0;
            op_a    <= 32'd0;
            op_b    <= 32'd0;
            op_sel  <= 2'd0;
            count   <= 32'd0;
            skip_wb <= 1'b0;
        end else if (state == IDLE) begin
            if (accept) begin
                op_a    <= A;
                op_b    <= B;
                op_sel  <= MDop[1:0];
                count   <= MDop[1] ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
                skip_wb <= 1'b0;
`ifdef MD_DIV0_GUARD_EN
                if (MDop[1] && (B == 32'd0)) begin
                    count   <= 32'd1;
                    skip_wb <= 1'b1;
                end
`endif
            end else if (!start) begin
                if (HIwrite) HI <= A;
                if (LOwrite) LO <= A;
            end
        end else begin
            // Any command arriving while running is ignored; the stall logic should prevent it.
            if (count == 32'd1) begin
                if (!skip_wb) begin
                    HI <= res_hi;
                    LO <= res_lo;
                end
            end else begin
                count <= count - 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table-driven and scoreboard-checked bench for md_unit.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, start, HIwrite, LOwrite;
    logic [2:0]  MDop;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    md_unit dut (
        .clk(clk), .reset(reset), .start(start), .MDop(MDop),
        .HIwrite(HIwrite), .LOwrite(LOwrite), .A(A), .B(B),
        .busy(busy), .HI(HI), .LO(LO)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a, b, hi, lo;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        int          cycles;
    } exp_t;

    exp_t scoreboard[$];
    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model built on 64-bit integer arithmetic rather than magnitude division.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo);
        longint sa, sbv, p;
        logic [63:0] up;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            3'd0: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
            3'd1: begin p = sa * sbv; up = 64'(p); hi = up[63:32]; lo = up[31:0]; end
            3'd2: if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                  else begin hi = a % b; lo = a / b; end
            3'd3: if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
                  else begin hi = 32'(sa % sbv); lo = 32'(sa / sbv); end
            default: ;
        endcase
    endtask

    task automatic collectResult(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        e = scoreboard.pop_front();
        checkOutput({name, " cycles"}, 32'(n), 32'(e.cycles));
        checkOutput({name, " HI"}, HI, e.hi);
        checkOutput({name, " LO"}, LO, e.lo);
    endtask

    // Called at a falling edge; returns at the falling edge on which busy is low again.
    task automatic applyStimulus(input string name, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                                 input int cycles);
        exp_t e;
        start = 1'b1; MDop = op; A = a; B = b;
        e.hi = hi; e.lo = lo; e.cycles = cycles;
        scoreboard.push_back(e);
        @(negedge clk);
        start = 1'b0;
        collectResult(name);
    endtask

    initial begin
        logic [31:0] mh, ml, ra, rb;
        logic [2:0]  rop;
        exp_t        e;

        vecs[0] = '{3'd0, 32'hFFFF_FFFF, 32'd2,          32'h0000_0001, 32'hFFFF_FFFE, 5};
        vecs[1] = '{3'd1, 32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 5};
        vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{3'd2, 32'd100,       32'd7,          32'd2,         32'd14,        10};
        vecs[4] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
        vecs[5] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[6] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[7] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
        vecs[8] = '{3'd2, 32'hFFFF_FFFF, 32'd16,         32'h0000_000F, 32'h0FFF_FFFF, 10};

        reset = 1'b1; start = 1'b0; HIwrite = 1'b0; LOwrite = 1'b0;
        MDop = 3'd0; A = 32'd0; B = 32'd0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset HI", HI, 32'd0);
        checkOutput("reset LO", LO, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        LOwrite = 1'b1; A = 32'h1234;
        @(negedge clk);
        LOwrite = 1'b0;
        checkOutput("mtlo LO", LO, 32'h1234);
        HIwrite = 1'b1; A = 32'h5678;
        @(negedge clk);
        HIwrite = 1'b0;
        checkOutput("mthi HI", HI, 32'h5678);
        checkOutput("mthi LO kept", LO, 32'h1234);
        HIwrite = 1'b1; LOwrite = 1'b1; A = 32'hABCD;
        @(negedge clk);
        HIwrite = 1'b0; LOwrite = 1'b0;
        checkOutput("mthi+mtlo HI", HI, 32'hABCD);
        checkOutput("mthi+mtlo LO", LO, 32'hABCD);

        // Consecutive table entries start the moment busy drops (back-to-back acceptance).
        for (int i = 0; i < 9; i++)
            applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                          vecs[i].hi, vecs[i].lo, vecs[i].cycles);

        for (int i = 0; i < 6; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom | 32'd1;
            model(rop, ra, rb, mh, ml);
            applyStimulus($sformatf("rand%0d", i), rop, ra, rb, mh, ml, rop[1] ? 10 : 5);
        end

        // Commands poked during RUN must be ignored.
        applyStimulus("pre mthi", 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5);
        HIwrite = 1'b1; A = 32'h0000_00AA;
        @(negedge clk);
        HIwrite = 1'b0;
        start = 1'b1; MDop = 3'd1; A = 32'd2; B = 32'd3;
        e.hi = 32'd0; e.lo = 32'd6; e.cycles = 4;
        scoreboard.push_back(e);
        @(negedge clk);
        start = 1'b0;
        HIwrite = 1'b1; LOwrite = 1'b1; start = 1'b1; MDop = 3'd2; A = 32'hFFFF_FFFF; B = 32'd1;
        @(negedge clk);
        HIwrite = 1'b0; LOwrite = 1'b0; start = 1'b0;
        checkOutput("run mthi HI", HI, 32'h0000_00AA);
        collectResult("run poke");
        checkOutput("run poke idle", {31'd0, busy}, 32'd0);

        start = 1'b1; MDop = 3'd1; A = 32'd3; B = 32'd4; HIwrite = 1'b1;
        e.hi = 32'd0; e.lo = 32'd12; e.cycles = 5;
        scoreboard.push_back(e);
        @(negedge clk);
        start = 1'b0; HIwrite = 1'b0;
        checkOutput("start+mthi HI", HI, 32'd0);
        collectResult("start+mthi");

        start = 1'b1; MDop = 3'b101; HIwrite = 1'b1; A = 32'hCAFE;
        @(negedge clk);
        start = 1'b0; HIwrite = 1'b0;
        checkOutput("badop busy", {31'd0, busy}, 32'd0);
        checkOutput("badop HI", HI, 32'd0);
        checkOutput("badop LO", LO, 32'd12);

        applyStimulus("pre div0", 3'd0, 32'd3, 32'd5, 32'd0, 32'd15, 5);
`ifdef MD_DIV0_GUARD_EN
        applyStimulus("div0", 3'd3, 32'h0000_0077, 32'd0, 32'd0, 32'd15, 1);
        applyStimulus("divu0", 3'd2, 32'h8000_0001, 32'd0, 32'd0, 32'd15, 1);
`else
        applyStimulus("div0", 3'd3, 32'h0000_0077, 32'd0, 32'h0000_0077, 32'hFFFF_FFFF, 10);
        applyStimulus("divu0", 3'd2, 32'h8000_0001, 32'd0, 32'h8000_0001, 32'hFFFF_FFFF, 10);
`endif

        // Reset during the third busy cycle of a divide aborts it with no late writeback.
        applyStimulus("pre abort", 3'd0, 32'h1_0000, 32'h1_0000, 32'd1, 32'd0, 5);
        start = 1'b1; MDop = 3'd3; A = 32'd100; B = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort HI", HI, 32'd0);
        checkOutput("abort LO", LO, 32'd0);
        repeat (12) @(negedge clk);
        checkOutput("abort late busy", {31'd0, busy}, 32'd0);
        checkOutput("abort late HI", HI, 32'd0);
        checkOutput("abort late LO", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
